// File: rtl/serial_stim_ctrl_if.sv
// Control/monitor bundle between a run source and the serial stimulus sequencer.
// master = run source and datapath side, slave = sequencer.
interface serial_stim_ctrl_if #(
    parameter int LEN_W = 8,
    parameter int REP_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] lo_len;
    logic [LEN_W-1:0] hi_len;
    logic [REP_W-1:0] reps;
    logic [3:0]       r;
    logic             a;
    logic             busy;
    logic             done;
    logic             zero_evt;
    logic [CNT_W-1:0] zero_cnt;

    modport master (
        output start, abort, lo_len, hi_len, reps, r,
        input  a, busy, done, zero_evt, zero_cnt
    );

    modport slave (
        input  start, abort, lo_len, hi_len, reps, r,
        output a, busy, done, zero_evt, zero_cnt
    );
endinterface

// File: rtl/serial_stim_ctrl.sv
// Serial burst sequencer: drives 'a' low/high for programmed phase lengths, counts r->0 events.
// Latency: first 'a' change lo cycles after the start-accept edge; all outputs registered.
// Backpressure: none; start is ignored while busy, abort ends a run on the next edge.
module serial_stim_ctrl #(
    parameter int LEN_W = 8,
    parameter int REP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                resetn,
    serial_stim_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_TAIL} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] lo_q, lo_d;
    logic [LEN_W-1:0] hi_q, hi_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             a_q, a_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_evt_q, zero_evt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [3:0]       r_d_q, r_d_d;

    logic [LEN_W-1:0] lo_eff, hi_eff;
    logic [REP_W-1:0] reps_eff;
    logic             run_clr;

    // Zero lengths/counts behave as one so a run always makes progress.
    assign lo_eff   = (bus.lo_len == '0) ? LEN_W'(1) : bus.lo_len;
    assign hi_eff   = (bus.hi_len == '0) ? LEN_W'(1) : bus.hi_len;
    assign reps_eff = (bus.reps   == '0) ? REP_W'(1) : bus.reps;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        rep_d      = rep_q;
        a_d        = a_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        run_clr    = 1'b0;
        r_d_d      = bus.r;
        zero_evt_d = (bus.r == 4'h0) && (r_d_q != 4'h0);

        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            a_d     = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    a_d = 1'b0;
                    if (bus.start && !bus.abort) begin
                        lo_d    = lo_eff;
                        hi_d    = hi_eff;
                        rep_d   = reps_eff;
                        cnt_d   = lo_eff - LEN_W'(1);
                        busy_d  = 1'b1;
                        run_clr = 1'b1;
                        state_d = S_LOW;
                    end
                end
                S_LOW: begin
                    if (cnt_q == '0) begin
                        a_d     = 1'b1;
                        cnt_d   = hi_q - LEN_W'(1);
                        state_d = S_HIGH;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q == '0) begin
                        a_d   = 1'b0;
                        cnt_d = lo_q - LEN_W'(1);
                        if (rep_q == REP_W'(1)) begin
                            state_d = S_TAIL;
                        end else begin
                            rep_d   = rep_q - REP_W'(1);
                            state_d = S_LOW;
                        end
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            endcase
        end

        // Counting is gated by busy after this edge, so events on the done or abort edge are dropped.
        if (run_clr) begin
            zero_cnt_d = '0;
        end else if (zero_evt_d && busy_d && (zero_cnt_q != '1)) begin
            zero_cnt_d = zero_cnt_q + CNT_W'(1);
        end else begin
            zero_cnt_d = zero_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lo_q       <= LEN_W'(1);
            hi_q       <= LEN_W'(1);
            rep_q      <= REP_W'(1);
            a_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_evt_q <= 1'b0;
            zero_cnt_q <= '0;
            r_d_q      <= 4'hF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            rep_q      <= rep_d;
            a_q        <= a_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            zero_evt_q <= zero_evt_d;
            zero_cnt_q <= zero_cnt_d;
            r_d_q      <= r_d_d;
        end
    end

    assign bus.a        = a_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.zero_evt = zero_evt_q;
    assign bus.zero_cnt = zero_cnt_q;
endmodule
